// File: rtl/mac_pkg.sv
// Shared opcodes and width helpers for the SIMD multiply-accumulate pipeline.
package mac_pkg;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    localparam int MODE_BIT = 2;

    // Low-part width of one lane in split mode.
    function automatic int rw_f(input int dw, input int lanes);
        return (2 * dw) / lanes;
    endfunction

    function automatic int acc_w_f(input int dw, input int lanes, input int guard);
        return 2 * dw + lanes * guard;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed lane: product, accumulate with wrap, and saturate to the 2*OPW-bit range.
module mac_lane
    import mac_pkg::*;
#(
    parameter int OPW = 8,
    parameter int GW  = 4
) (
    input  logic        [1:0]          op,
    input  logic signed [OPW-1:0]      a,
    input  logic signed [OPW-1:0]      b,
    input  logic signed [2*OPW+GW-1:0] acc_in,
    output logic signed [2*OPW+GW-1:0] acc_out,
    output logic                       sat
);

    localparam int PW = 2 * OPW;
    localparam int LW = PW + GW;

    logic signed [PW-1:0] w_prod;
    logic signed [LW-1:0] w_prod_ext;
    logic signed [LW-1:0] w_max;
    logic signed [LW-1:0] w_min;

    assign w_prod     = PW'(a) * PW'(b);
    assign w_prod_ext = {{GW{w_prod[PW-1]}}, w_prod};
    assign w_max      = {{(GW + 1){1'b0}}, {(PW - 1){1'b1}}};
    assign w_min      = {{(GW + 1){1'b1}}, {(PW - 1){1'b0}}};

    always_comb begin
        acc_out = '0;
        sat     = 1'b0;
        case (op)
            OP_CLR: acc_out = '0;
            OP_MUL: acc_out = w_prod_ext;
            OP_MAC: acc_out = acc_in + w_prod_ext;
            default: begin
                if (acc_in > w_max) begin
                    acc_out = w_max;
                    sat     = 1'b1;
                end else if (acc_in < w_min) begin
                    acc_out = w_min;
                    sat     = 1'b1;
                end else begin
                    acc_out = {{GW{acc_in[PW-1]}}, acc_in[PW-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/simd_mac_pipe.sv
// Signed MAC with guard bits, full/split lane modes and an LAT-deep output pipeline.
module simd_mac_pipe
    import mac_pkg::*;
#(
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int GUARD = 4,
    parameter int LAT   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   in_valid,
    input  logic [2:0]             instruction,
    input  logic signed [DW-1:0]   multiplier,
    input  logic signed [DW-1:0]   multiplicand,
    input  logic                   sat_clr,
    output logic                   out_valid,
    output logic [LANES*GUARD-1:0] protect,
    output logic [2*DW-1:0]        result,
    output logic [LANES-1:0]       sat_flag
);

    localparam int RW  = rw_f(DW, LANES);
    localparam int AW  = acc_w_f(DW, LANES, GUARD);
    localparam int OPL = DW / LANES;
    localparam int LW  = RW + GUARD;
    localparam int GT  = LANES * GUARD;

    logic signed [AW-1:0] r_acc;
    logic                 r_acc_vld;
    logic [LANES-1:0]     r_sat;

    logic [1:0]           w_op;
    logic                 w_split;
    logic signed [AW-1:0] w_full_acc;
    logic signed [AW-1:0] w_split_acc;
    logic signed [AW-1:0] w_acc_nxt;
    logic                 w_full_sat;
    logic [LANES-1:0]     w_split_sat;
    logic [LANES-1:0]     w_sat_set;

    assign w_op    = instruction[1:0];
    assign w_split = instruction[MODE_BIT];

    mac_lane #(.OPW(DW), .GW(GT)) u_full (
        .op      (w_op),
        .a       (multiplier),
        .b       (multiplicand),
        .acc_in  (r_acc),
        .acc_out (w_full_acc),
        .sat     (w_full_sat)
    );

    // Lane i owns low slice [i*RW +: RW] and guard slice [2*DW + i*GUARD +: GUARD].
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [LW-1:0] w_in;
        logic signed [LW-1:0] w_out;

        assign w_in = {r_acc[2*DW + gi*GUARD +: GUARD], r_acc[gi*RW +: RW]};

        mac_lane #(.OPW(OPL), .GW(GUARD)) u_lane (
            .op      (w_op),
            .a       (multiplier[gi*OPL +: OPL]),
            .b       (multiplicand[gi*OPL +: OPL]),
            .acc_in  (w_in),
            .acc_out (w_out),
            .sat     (w_split_sat[gi])
        );

        assign w_split_acc[2*DW + gi*GUARD +: GUARD] = w_out[RW +: GUARD];
        assign w_split_acc[gi*RW +: RW]              = w_out[RW-1:0];
    end

    assign w_acc_nxt = w_split ? w_split_acc : w_full_acc;
    assign w_sat_set = (w_op != OP_SAT) ? '0 :
                       (w_split ? w_split_sat : LANES'(w_full_sat));

    // Accumulator stage: a flag being set on this edge outranks sat_clr.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
            r_sat     <= '0;
        end else if (!stall) begin
            r_acc_vld <= in_valid;
            if (in_valid) begin
                r_acc <= w_acc_nxt;
            end
            r_sat <= (sat_clr ? '0 : r_sat) | (in_valid ? w_sat_set : '0);
        end
    end

    logic          r_vld_p  [LAT];
    logic [AW-1:0] r_data_p [LAT];
    logic          w_vld_in [LAT];
    logic [AW-1:0] w_data_in[LAT];

    assign w_vld_in[0]  = r_acc_vld;
    assign w_data_in[0] = r_acc;
    for (genvar gs = 1; gs < LAT; gs++) begin : g_link
        assign w_vld_in[gs]  = r_vld_p[gs-1];
        assign w_data_in[gs] = r_data_p[gs-1];
    end

    // Output pipeline: the exit stage only captures valid snapshots so result/protect hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld_p[i]  <= 1'b0;
                r_data_p[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld_p[i] <= w_vld_in[i];
                if (w_vld_in[i] || (i < LAT - 1)) begin
                    r_data_p[i] <= w_data_in[i];
                end
            end
        end
    end

    assign out_valid = r_vld_p[LAT-1];
    assign protect   = r_data_p[LAT-1][AW-1:2*DW];
    assign result    = r_data_p[LAT-1][2*DW-1:0];
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_simd_mac_pipe.sv
// Scoreboard bench for simd_mac_pipe: lane-level reference model, queued snapshots, cycle-level monitor.
module tb_simd_mac_pipe;

    localparam int DW    = 16;
    localparam int LANES = 2;
    localparam int GUARD = 4;
    localparam int LAT   = 2;
    localparam int AW    = 2 * DW + LANES * GUARD;
    localparam int GT    = LANES * GUARD;

    logic             clk;
    logic             reset_n;
    logic             stall;
    logic             in_valid;
    logic [2:0]       instruction;
    logic [DW-1:0]    multiplier;
    logic [DW-1:0]    multiplicand;
    logic             sat_clr;
    logic             out_valid;
    logic [GT-1:0]    protect;
    logic [2*DW-1:0]  result;
    logic [LANES-1:0] sat_flag;

    simd_mac_pipe #(.DW(DW), .LANES(LANES), .GUARD(GUARD), .LAT(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .in_valid     (in_valid),
        .instruction  (instruction),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .sat_clr      (sat_clr),
        .out_valid    (out_valid),
        .protect      (protect),
        .result       (result),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] snap;
    } exp_t;

    exp_t             q[$];
    logic [AW-1:0]    m_acc;
    logic [LANES-1:0] m_sat;
    int unsigned      ucnt;
    int               n_chk;
    int               n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: interpret the accumulator as independent signed lanes and apply the opcode with plain integers.
    function automatic logic [AW-1:0] model_step(input logic [AW-1:0] acc, input logic split,
                                                 input logic [1:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, output logic [LANES-1:0] setf);
        logic [AW-1:0] nxt;
        int nl, opw, rw, gw, lw;
        longint v, pa, pb, p, mx, mn;
        nxt  = acc;
        setf = '0;
        nl   = split ? LANES : 1;
        opw  = DW / nl;
        rw   = 2 * opw;
        gw   = GT / nl;
        lw   = rw + gw;
        for (int l = 0; l < nl; l++) begin
            v = 0;
            for (int j = 0; j < rw; j++) v[j] = acc[l*rw + j];
            for (int j = 0; j < gw; j++) v[rw + j] = acc[2*DW + l*gw + j];
            if (v[lw-1]) v = v - (64'sd1 <<< lw);
            pa = 0;
            pb = 0;
            for (int j = 0; j < opw; j++) begin
                pa[j] = a[l*opw + j];
                pb[j] = b[l*opw + j];
            end
            if (pa[opw-1]) pa = pa - (64'sd1 <<< opw);
            if (pb[opw-1]) pb = pb - (64'sd1 <<< opw);
            p  = pa * pb;
            mx = (64'sd1 <<< (rw - 1)) - 1;
            mn = -(64'sd1 <<< (rw - 1));
            case (op)
                2'b00: v = 0;
                2'b01: v = p;
                2'b10: v = v + p;
                default: begin
                    if (v > mx) begin
                        v = mx;
                        setf[l] = 1'b1;
                    end else if (v < mn) begin
                        v = mn;
                        setf[l] = 1'b1;
                    end
                end
            endcase
            for (int j = 0; j < rw; j++) nxt[l*rw + j] = v[j];
            for (int j = 0; j < gw; j++) nxt[2*DW + l*gw + j] = v[rw + j];
        end
        return nxt;
    endfunction

    task automatic drive(input logic v, input logic [2:0] ins, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic st, input logic sc);
        logic [LANES-1:0] setf;
        exp_t e;
        @(negedge clk);
        reset_n      = 1'b1;
        in_valid     = v;
        instruction  = ins;
        multiplier   = a;
        multiplicand = b;
        stall        = st;
        sat_clr      = sc;
        if (!st) begin
            setf = '0;
            if (v) begin
                m_acc  = model_step(m_acc, ins[2], ins[1:0], a, b, setf);
                e.due  = ucnt + 1 + LAT;
                e.snap = m_acc;
                q.push_back(e);
            end
            m_sat = (sc ? '0 : m_sat) | setf;
        end
    endtask

    task automatic bub();
        drive(1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        stall    = 1'($urandom_range(0, 1));
        sat_clr  = 1'b0;
        m_acc    = '0;
        m_sat    = '0;
        q.delete();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, compare the outputs against the scoreboard head and the held snapshot.
    initial begin
        logic          was_rst, was_stall, exp_v;
        logic [AW-1:0] last;
        exp_v = 1'b0;
        last  = '0;
        forever begin
            @(posedge clk);
            was_rst   = !reset_n;
            was_stall = stall;
            if (!was_rst && !was_stall) ucnt++;
            #1;
            if (was_rst) begin
                exp_v = 1'b0;
                last  = '0;
            end else if (!was_stall) begin
                exp_v = (q.size() > 0) && (q[0].due == ucnt);
                if (exp_v) begin
                    last = q[0].snap;
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due < ucnt) begin
                    chk("mon_missed_snapshot", 64'(q[0].due), 64'(ucnt));
                    void'(q.pop_front());
                end
            end
            chk("mon_out_valid", 64'(out_valid), 64'(exp_v));
            chk("mon_result", 64'(result), 64'(last[2*DW-1:0]));
            chk("mon_protect", 64'(protect), 64'(last[AW-1:2*DW]));
            chk("mon_sat_flag", 64'(sat_flag), 64'(m_sat));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        ucnt  = 0;
        m_acc = '0;
        m_sat = '0;
        reset_n = 1'b0; stall = 1'b0; in_valid = 1'b0; instruction = '0;
        multiplier = '0; multiplicand = '0; sat_clr = 1'b0;
        after_edge();
        after_edge();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);

        // Full-mode mul: -1 * 2
        drive(1'b1, 3'b001, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_protect", 64'(protect), 64'hFF);
        chk("t1_result", 64'(result), 64'hFFFFFFFE);

        // Accumulate into guard bits, then saturate
        drive(1'b1, 3'b001, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 3'b010, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t2_protect", 64'(protect), 64'h00);
        chk("t2_result", 64'(result), 64'hFFFC0004);
        drive(1'b1, 3'b011, '0, '0, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t2_sat_result", 64'(result), 64'h7FFFFFFF);
        chk("t2_sat_protect", 64'(protect), 64'h00);
        chk("t2_sat_flag", 64'(sat_flag), 64'h1);

        // Split-mode mul, then a zero mac must leave both lanes intact
        drive(1'b1, 3'b101, 16'h80FF, 16'h7F02, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t3_protect", 64'(protect), 64'hFF);
        chk("t3_result", 64'(result), 64'hC080FFFE);
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t3_mac0_result", 64'(result), 64'hC080FFFE);
        chk("t3_mac0_protect", 64'(protect), 64'hFF);

        // Stall for 3 cycles with a clear presented
        drive(1'b1, 3'b001, 16'h0003, 16'h0004, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 3'b000, '0, '0, 1'b1, 1'b1);
        bub();
        after_edge();
        chk("t4_valid_early", 64'(out_valid), 64'd0);
        chk("t4_result_held", 64'(result), 64'hC080FFFE);
        bub();
        after_edge();
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_result", 64'(result), 64'd12);
        drive(1'b1, 3'b010, 16'h0001, 16'h0001, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t4_not_cleared", 64'(result), 64'd13);

        // Alternating valid
        drive(1'b1, 3'b010, 16'h0001, 16'h0001, 1'b0, 1'b0);
        bub();
        drive(1'b1, 3'b010, 16'h0001, 16'h0001, 1'b0, 1'b0);
        after_edge();
        chk("t5_valid_1", 64'(out_valid), 64'd1);
        chk("t5_result_1", 64'(result), 64'd14);
        bub();
        after_edge();
        chk("t5_valid_0", 64'(out_valid), 64'd0);
        chk("t5_result_hold", 64'(result), 64'd14);
        bub();
        after_edge();
        chk("t5_result_2", 64'(result), 64'd15);

        // sat_clr alone clears; a set on the same edge as sat_clr wins; stall ignores sat_clr
        drive(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);
        after_edge();
        chk("t5_satclr", 64'(sat_flag), 64'h0);
        drive(1'b1, 3'b001, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 3'b010, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drive(1'b1, 3'b011, '0, '0, 1'b0, 1'b1);
        after_edge();
        chk("t5_set_beats_clr", 64'(sat_flag), 64'h1);
        drive(1'b0, 3'b000, '0, '0, 1'b1, 1'b1);
        after_edge();
        chk("t5_stall_keeps_flag", 64'(sat_flag), 64'h1);
        bub(); bub();
        after_edge();
        chk("t5_sat_result", 64'(result), 64'h7FFFFFFF);

        // Reset with entries in flight
        drive(1'b1, 3'b001, 16'h0002, 16'h0003, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 16'h0004, 16'h0005, 1'b0, 1'b0);
        do_reset();
        after_edge();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_result", 64'(result), 64'd0);
        chk("t6_protect", 64'(protect), 64'd0);
        chk("t6_sat", 64'(sat_flag), 64'd0);
        drive(1'b1, 3'b010, 16'h0003, 16'h0005, 1'b0, 1'b0);
        bub(); bub();
        after_edge();
        chk("t6_mac_after_reset", 64'(result), 64'd15);
        chk("t6_protect_after", 64'(protect), 64'd0);

        // Randomised traffic, including mode switches, stalls and occasional resets
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [DW-1:0] a, b;
            r = $urandom_range(0, 99);
            a = DW'($urandom);
            b = DW'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            if ($urandom_range(0, 7) == 0) b = 16'h7FFF;
            if (r < 2) do_reset();
            else drive(($urandom_range(0, 9) < 7), 3'($urandom), a, b,
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end
        repeat (LAT + 3) bub();
        after_edge();
        chk("drain_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
